// File: rtl/mcpnr_switch_reader.sv
// Switch-bank front end: two-flop synchroniser, per-word debounce, and a
// valid/ready event stage that reports each committed word with its change mask.
module mcpnr_switch_reader #(
    parameter int NSWITCH         = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NSWITCH-1:0] sw_i,
    output logic [NSWITCH-1:0] data_o,
    output logic [NSWITCH-1:0] changed_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               overrun_o,
    input  logic               clr_overrun_i
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NSWITCH-1:0] sync1_q, sync1_d;
    logic [NSWITCH-1:0] sync2_q, sync2_d;
    logic [NSWITCH-1:0] cand_q, cand_d;
    logic [NSWITCH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NSWITCH-1:0] data_q, data_d;
    logic [NSWITCH-1:0] changed_q, changed_d;
    logic               overrun_q, overrun_d;
    logic               commit;
    logic [NSWITCH-1:0] delta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            changed_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            changed_q <= changed_d;
            overrun_q <= overrun_d;
        end
    end

    // Debounce: any disagreement restarts the count; the word commits only
    // once the counter has saturated and the candidate differs from stable.
    always_comb begin
        sync1_d  = sw_i;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        commit   = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (cand_q != stable_q) begin
            commit   = 1'b1;
            stable_d = cand_q;
        end
    end

    assign delta = stable_q ^ cand_q;

    // Event FSM: an unaccepted word is overwritten by a newer commit, its
    // change mask accumulated so the consumer still sees every touched bit.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        changed_d = changed_q;
        overrun_d = overrun_q;
        if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (commit) begin
                    data_d    = cand_q;
                    changed_d = delta;
                    state_d   = PEND;
                end
            end
            PEND: begin
                if (commit) begin
                    data_d = cand_q;
                    if (ready_i) begin
                        changed_d = delta;
                    end else begin
                        changed_d = changed_q | delta;
                        overrun_d = 1'b1;
                    end
                end else if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_o    = data_q;
    assign changed_o = changed_q;
    assign valid_o   = (state_q == PEND);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_mcpnr_switch_reader.sv
// Directed bench for mcpnr_switch_reader: reset, commit latency, glitch
// rejection, coalescing/overrun, commit-with-handshake and mid-transaction reset.
module tb_mcpnr_switch_reader;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw_i;
    logic [15:0] data_o;
    logic [15:0] changed_o;
    logic        valid_o;
    logic        ready_i;
    logic        overrun_o;
    logic        clr_overrun_i;

    int n_checks;
    int n_fail;

    mcpnr_switch_reader #(
        .NSWITCH        (16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_i         (sw_i),
        .data_o       (data_o),
        .changed_o    (changed_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .overrun_o    (overrun_o),
        .clr_overrun_i(clr_overrun_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int seen_valid;
        int seen_ovr;
        rst_n = 1'b0; sw_i = 16'h0000; ready_i = 1'b0; clr_overrun_i = 1'b0;
        tick(); tick();
        n_checks++;
        if (valid_o !== 1'b0 || data_o !== 16'h0 || changed_o !== 16'h0 || overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%0b d=%h c=%h o=%0b want all 0", valid_o, data_o, changed_o, overrun_o);
        end
        rst_n = 1'b1;
        seen_valid = 0; seen_ovr = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (valid_o !== 1'b0) seen_valid++;
            if (overrun_o !== 1'b0) seen_ovr++;
        end
        n_checks++;
        if (seen_valid != 0 || seen_ovr != 0) begin
            n_fail++;
            $display("FAIL reset_idle got valid_cycles=%0d ovr_cycles=%0d want 0/0", seen_valid, seen_ovr);
        end
    endtask

    task automatic test_latency();
        ready_i = 1'b1;
        sw_i = 16'hA5C3;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_early_valid got %0b want 0 after 6 edges", valid_o);
        end
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== 16'hA5C3 || changed_o !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL lat_edge7 got v=%0b d=%h c=%h want v=1 d=a5c3 c=a5c3", valid_o, data_o, changed_o);
        end
        tick();
        n_checks++;
        if (valid_o !== 1'b0 || data_o !== 16'hA5C3 || changed_o !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL lat_accept got v=%0b d=%h c=%h want v=0 d=a5c3 c=a5c3", valid_o, data_o, changed_o);
        end
        // return to all-zero so the glitch tests start from a clean word
        sw_i = 16'h0000;
        for (int i = 0; i < 12; i++) tick();
        n_checks++;
        if (valid_o !== 1'b0 || data_o !== 16'h0000 || changed_o !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL lat_to_zero got v=%0b d=%h c=%h want v=0 d=0000 c=a5c3", valid_o, data_o, changed_o);
        end
    endtask

    task automatic test_glitch();
        int          n_ev;
        int          ev_at   [2];
        logic [15:0] ev_data [2];
        logic [15:0] ev_chg  [2];
        ready_i = 1'b1;
        n_ev = 0;
        for (int i = 0; i < 20; i++) begin
            sw_i = (i < 3) ? 16'h0001 : 16'h0000;
            tick();
            if (valid_o === 1'b1) n_ev++;
        end
        n_checks++;
        if (n_ev != 0) begin
            n_fail++;
            $display("FAIL glitch3_events got %0d want 0", n_ev);
        end
        n_ev = 0;
        for (int i = 0; i < 25; i++) begin
            sw_i = (i < 5) ? 16'h0001 : 16'h0000;
            tick();
            if (valid_o === 1'b1) begin
                if (n_ev < 2) begin
                    ev_at[n_ev] = i; ev_data[n_ev] = data_o; ev_chg[n_ev] = changed_o;
                end
                n_ev++;
            end
        end
        n_checks++;
        if (n_ev != 2) begin
            n_fail++;
            $display("FAIL pulse_events got %0d want 2", n_ev);
        end else begin
            n_checks++;
            if (ev_at[0] != 6 || ev_data[0] !== 16'h0001 || ev_chg[0] !== 16'h0001) begin
                n_fail++;
                $display("FAIL pulse_ev0 got at=%0d d=%h c=%h want at=6 d=0001 c=0001", ev_at[0], ev_data[0], ev_chg[0]);
            end
            n_checks++;
            if (ev_at[1] != 11 || ev_data[1] !== 16'h0000 || ev_chg[1] !== 16'h0001) begin
                n_fail++;
                $display("FAIL pulse_ev1 got at=%0d d=%h c=%h want at=11 d=0000 c=0001", ev_at[1], ev_data[1], ev_chg[1]);
            end
        end
    endtask

    task automatic test_overrun();
        ready_i = 1'b0;
        sw_i = 16'h00FF;
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== 16'h00FF || changed_o !== 16'h00FF || overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_first got v=%0b d=%h c=%h o=%0b want 1/00ff/00ff/0", valid_o, data_o, changed_o, overrun_o);
        end
        sw_i = 16'h0FFF;
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== 16'h0FFF || changed_o !== 16'h0FFF || overrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_coalesce got v=%0b d=%h c=%h o=%0b want 1/0fff/0fff/1", valid_o, data_o, changed_o, overrun_o);
        end
        clr_overrun_i = 1'b1;
        tick();
        n_checks++;
        if (overrun_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 16'h0FFF) begin
            n_fail++;
            $display("FAIL ovr_clear got o=%0b v=%0b d=%h want 0/1/0fff", overrun_o, valid_o, data_o);
        end
        // clear held across another coalescing commit: the set must win
        sw_i = 16'h3FFF;
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (overrun_o !== 1'b1 || data_o !== 16'h3FFF || changed_o !== 16'h3FFF) begin
            n_fail++;
            $display("FAIL ovr_set_wins got o=%0b d=%h c=%h want 1/3fff/3fff", overrun_o, data_o, changed_o);
        end
        tick();
        n_checks++;
        if (overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear2 got %0b want 0", overrun_o);
        end
        clr_overrun_i = 1'b0;
        ready_i = 1'b1;
        tick();
        n_checks++;
        if (valid_o !== 1'b0 || data_o !== 16'h3FFF || changed_o !== 16'h3FFF) begin
            n_fail++;
            $display("FAIL ovr_accept got v=%0b d=%h c=%h want 0/3fff/3fff", valid_o, data_o, changed_o);
        end
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b0;
        sw_i = 16'h0000;
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== 16'h0000 || changed_o !== 16'h3FFF) begin
            n_fail++;
            $display("FAIL b2b_first got v=%0b d=%h c=%h want 1/0000/3fff", valid_o, data_o, changed_o);
        end
        sw_i = 16'h0001;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== 16'h0000 || changed_o !== 16'h3FFF) begin
            n_fail++;
            $display("FAIL b2b_hold got v=%0b d=%h c=%h want 1/0000/3fff", valid_o, data_o, changed_o);
        end
        ready_i = 1'b1;
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== 16'h0001 || changed_o !== 16'h0001 || overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_same_edge got v=%0b d=%h c=%h o=%0b want 1/0001/0001/0", valid_o, data_o, changed_o, overrun_o);
        end
        tick();
        n_checks++;
        if (valid_o !== 1'b0 || data_o !== 16'h0001) begin
            n_fail++;
            $display("FAIL b2b_retire got v=%0b d=%h want 0/0001", valid_o, data_o);
        end
    endtask

    task automatic test_reset_mid();
        int hit;
        ready_i = 1'b0;
        sw_i = 16'h8001;
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== 16'h8001 || changed_o !== 16'h8000) begin
            n_fail++;
            $display("FAIL rmid_pend got v=%0b d=%h c=%h want 1/8001/8000", valid_o, data_o, changed_o);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || data_o !== 16'h0 || changed_o !== 16'h0 || overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async got v=%0b d=%h c=%h o=%0b want all 0", valid_o, data_o, changed_o, overrun_o);
        end
        tick();
        rst_n = 1'b1;
        ready_i = 1'b1;
        hit = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid_o === 1'b1 && hit < 0) begin
                hit = i;
                n_checks++;
                if (data_o !== 16'h8001 || changed_o !== 16'h8001) begin
                    n_fail++;
                    $display("FAIL rmid_fresh got d=%h c=%h want 8001/8001", data_o, changed_o);
                end
            end
        end
        n_checks++;
        if (hit != 6) begin
            n_fail++;
            $display("FAIL rmid_latency got edge_index=%0d want 6", hit);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_latency();
        test_glitch();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
